// File: rtl/tex_dcr_staged_bank_pkg.sv
// Shared types and constants for the staged texture DCR bank: field widths,
// DCR offset map, the per-stage texture state struct and the address decoder.
package tex_dcr_staged_bank_pkg;

  localparam int NUM_MIPS        = 12;
  localparam int MIP_IDX_BITS    = $clog2(NUM_MIPS);

  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_MIPOFF_BITS = 20;

  localparam logic [31:0] VX_DCR_TEX_BASE    = 32'h0000_0100;
  localparam logic [31:0] DCR_TEX_STAGE      = 32'd0;
  localparam logic [31:0] DCR_TEX_ADDR       = 32'd1;
  localparam logic [31:0] DCR_TEX_FORMAT     = 32'd2;
  localparam logic [31:0] DCR_TEX_FILTER     = 32'd3;
  localparam logic [31:0] DCR_TEX_WRAP       = 32'd4;
  localparam logic [31:0] DCR_TEX_LOGDIM     = 32'd5;
  localparam logic [31:0] DCR_TEX_COMMIT     = 32'd6;
  localparam logic [31:0] DCR_TEX_MIPOFF0    = 32'd7;

  function automatic logic [31:0] dcr_tex_mipoff(input int unsigned j);
    return DCR_TEX_MIPOFF0 + 32'(j);
  endfunction

  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                   addr;
    logic [TEX_FORMAT_BITS-1:0]                 format;
    logic [TEX_FILTER_BITS-1:0]                 filter;
    logic [1:0][TEX_WRAP_BITS-1:0]              wrap;
    logic [1:0][TEX_LOD_BITS-1:0]               logdim;
    logic [NUM_MIPS-1:0][TEX_MIPOFF_BITS-1:0]   mipoff;
  } tex_dcrs_t;

  typedef enum logic [3:0] {
    DCR_NONE,
    DCR_STAGE,
    DCR_ADDR,
    DCR_FORMAT,
    DCR_FILTER,
    DCR_WRAP,
    DCR_LOGDIM,
    DCR_COMMIT,
    DCR_MIPOFF
  } dcr_sel_e;

  typedef struct packed {
    dcr_sel_e                  sel;
    logic [MIP_IDX_BITS-1:0]   mip;
  } dcr_dec_t;

  // off is the address already rebased to VX_DCR_TEX_BASE; addresses below
  // the base wrap to huge values and fall out of the map.
  function automatic dcr_dec_t dcr_decode(input logic [31:0] off);
    dcr_dec_t d;
    d.sel = DCR_NONE;
    d.mip = '0;
    case (off)
      DCR_TEX_STAGE:  d.sel = DCR_STAGE;
      DCR_TEX_ADDR:   d.sel = DCR_ADDR;
      DCR_TEX_FORMAT: d.sel = DCR_FORMAT;
      DCR_TEX_FILTER: d.sel = DCR_FILTER;
      DCR_TEX_WRAP:   d.sel = DCR_WRAP;
      DCR_TEX_LOGDIM: d.sel = DCR_LOGDIM;
      DCR_TEX_COMMIT: d.sel = DCR_COMMIT;
      default: begin
        if (off >= DCR_TEX_MIPOFF0 && off < dcr_tex_mipoff(NUM_MIPS)) begin
          d.sel = DCR_MIPOFF;
          d.mip = MIP_IDX_BITS'(off - DCR_TEX_MIPOFF0);
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tex_dcr_staged_bank_stage_ctl.sv
// Per-stage commit control: in-flight counter, armed-commit flag, commit
// strobe, request hold-off term and underflow detect.
module tex_dcr_stage_ctl #(
  parameter int CNT_BITS = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic accept,
  input  logic retire,
  input  logic arm,
  output logic pending,
  output logic commit_fire,
  output logic ready,
  output logic underflow
);

  logic [CNT_BITS-1:0] cnt;

  assign commit_fire = pending && (cnt == '0);
  assign ready       = !pending && (cnt != '1);
  assign underflow   = retire && !accept && (cnt == '0);

  // An arm arriving while already pending is a no-op, so the fire edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else begin
      if (commit_fire) begin
        pending <= 1'b0;
      end else if (arm) begin
        pending <= 1'b1;
      end
      if (accept && !retire) begin
        cnt <= cnt + 1'b1;
      end else if (retire && !accept && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tex_dcr_staged_bank.sv
// Staged texture DCR bank: shadow state written over DCR, copied atomically to
// the active set once a stage's armed commit sees its in-flight count drain.
module tex_dcr_staged_bank
  import tex_dcr_staged_bank_pkg::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int CNT_BITS      = 6,
  parameter int DCR_ADDR_BITS = 12,
  localparam int SB = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dcr_write_valid,
  input  logic [DCR_ADDR_BITS-1:0] dcr_write_addr,
  input  logic [31:0]              dcr_write_data,
  input  logic                     dcr_read_valid,
  input  logic [DCR_ADDR_BITS-1:0] dcr_read_addr,
  output logic                     dcr_rsp_valid,
  output logic [31:0]              dcr_rsp_data,
  input  logic                     req_valid,
  input  logic [SB-1:0]            req_stage,
  output logic                     req_ready,
  input  logic                     rsp_fire,
  input  logic [SB-1:0]            rsp_stage,
  input  logic [SB-1:0]            stage,
  output tex_dcrs_t                tex_dcrs,
  output logic [NUM_STAGES-1:0]    commit_pending,
  output logic                     err_underflow
);

  // Out-of-range indices collapse onto the last stage; with one stage every
  // index becomes 0.
  function automatic logic [SB-1:0] clamp_idx(input logic [SB-1:0] v);
    if (32'(v) >= 32'(NUM_STAGES)) return SB'(NUM_STAGES - 1);
    return v;
  endfunction

  logic [SB-1:0]         cur_stage;
  logic [SB-1:0]         req_idx, rsp_idx, lkp_idx;
  logic [NUM_STAGES-1:0] pend_vec, fire_vec, ready_vec, uflow_vec;
  logic [NUM_STAGES-1:0] accept_vec, retire_vec, arm_vec;
  logic                  req_accept;

  tex_dcrs_t shadow [NUM_STAGES];
  tex_dcrs_t active [NUM_STAGES];
  tex_dcrs_t shadow_upd;
  tex_dcrs_t rd_cur;
  logic      wr_field;
  dcr_dec_t  wr_dec, rd_dec;
  logic [31:0] rd_data;

  assign req_idx = clamp_idx(req_stage);
  assign rsp_idx = clamp_idx(rsp_stage);
  assign lkp_idx = clamp_idx(stage);

  assign wr_dec = dcr_decode(32'(dcr_write_addr) - VX_DCR_TEX_BASE);
  assign rd_dec = dcr_decode(32'(dcr_read_addr) - VX_DCR_TEX_BASE);

  assign req_ready      = ready_vec[req_idx];
  assign req_accept     = req_valid && req_ready;
  assign commit_pending = pend_vec;
  assign tex_dcrs       = active[lkp_idx];

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign accept_vec[s] = req_accept && (req_idx == SB'(s));
    assign retire_vec[s] = rsp_fire && (rsp_idx == SB'(s));
    assign arm_vec[s]    = dcr_write_valid && (wr_dec.sel == DCR_COMMIT) &&
                           (cur_stage == SB'(s));

    tex_dcr_stage_ctl #(.CNT_BITS(CNT_BITS)) u_ctl (
      .clk         (clk),
      .reset_n     (reset_n),
      .accept      (accept_vec[s]),
      .retire      (retire_vec[s]),
      .arm         (arm_vec[s]),
      .pending     (pend_vec[s]),
      .commit_fire (fire_vec[s]),
      .ready       (ready_vec[s]),
      .underflow   (uflow_vec[s])
    );
  end

  always_comb begin
    shadow_upd = shadow[cur_stage];
    wr_field   = 1'b0;
    if (dcr_write_valid) begin
      wr_field = 1'b1;
      case (wr_dec.sel)
        DCR_ADDR:   shadow_upd.addr   = dcr_write_data[TEX_ADDR_BITS-1:0];
        DCR_FORMAT: shadow_upd.format = dcr_write_data[TEX_FORMAT_BITS-1:0];
        DCR_FILTER: shadow_upd.filter = dcr_write_data[TEX_FILTER_BITS-1:0];
        DCR_WRAP: begin
          shadow_upd.wrap[0] = dcr_write_data[0 +: TEX_WRAP_BITS];
          shadow_upd.wrap[1] = dcr_write_data[16 +: TEX_WRAP_BITS];
        end
        DCR_LOGDIM: begin
          shadow_upd.logdim[0] = dcr_write_data[0 +: TEX_LOD_BITS];
          shadow_upd.logdim[1] = dcr_write_data[16 +: TEX_LOD_BITS];
        end
        DCR_MIPOFF: shadow_upd.mipoff[wr_dec.mip] = dcr_write_data[TEX_MIPOFF_BITS-1:0];
        default:    wr_field = 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_cur  = shadow[cur_stage];
    rd_data = '0;
    case (rd_dec.sel)
      DCR_STAGE:  rd_data = 32'(cur_stage);
      DCR_ADDR:   rd_data = 32'(rd_cur.addr);
      DCR_FORMAT: rd_data = 32'(rd_cur.format);
      DCR_FILTER: rd_data = 32'(rd_cur.filter);
      DCR_WRAP: begin
        rd_data[0 +: TEX_WRAP_BITS]  = rd_cur.wrap[0];
        rd_data[16 +: TEX_WRAP_BITS] = rd_cur.wrap[1];
      end
      DCR_LOGDIM: begin
        rd_data[0 +: TEX_LOD_BITS]  = rd_cur.logdim[0];
        rd_data[16 +: TEX_LOD_BITS] = rd_cur.logdim[1];
      end
      DCR_COMMIT: rd_data = 32'(pend_vec[cur_stage]);
      DCR_MIPOFF: rd_data = 32'(rd_cur.mipoff[rd_dec.mip]);
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STAGES; s++) shadow[s] <= '0;
      cur_stage     <= '0;
      err_underflow <= 1'b0;
      dcr_rsp_valid <= 1'b0;
      dcr_rsp_data  <= '0;
    end else begin
      if (wr_field) shadow[cur_stage] <= shadow_upd;
      if (dcr_write_valid && wr_dec.sel == DCR_STAGE) begin
        cur_stage <= clamp_idx(dcr_write_data[SB-1:0]);
      end
      if (|uflow_vec) err_underflow <= 1'b1;
      dcr_rsp_valid <= dcr_read_valid;
      if (dcr_read_valid) dcr_rsp_data <= rd_data;
    end
  end

  // Commit copies the pre-edge shadow, so a same-edge shadow write waits for
  // the next COMMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STAGES; s++) active[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (fire_vec[s]) active[s] <= shadow[s];
      end
    end
  end

endmodule

// File: tb/tb_tex_dcr_staged_bank.sv
// Bench for tex_dcr_staged_bank: register-image reference model, read-back
// scoreboard, directed scenarios followed by randomized traffic.
module tb_tex_dcr_staged_bank;
  import tex_dcr_staged_bank_pkg::*;

  localparam int NS      = 4;
  localparam int BASE    = 'h100;
  localparam int NOFF    = 7 + NUM_MIPS;
  localparam int CNT_MAX = 63;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dcr_write_valid = 1'b0;
  logic [11:0] dcr_write_addr = '0;
  logic [31:0] dcr_write_data = '0;
  logic        dcr_read_valid = 1'b0;
  logic [11:0] dcr_read_addr = '0;
  logic        dcr_rsp_valid;
  logic [31:0] dcr_rsp_data;
  logic        req_valid = 1'b0;
  logic [1:0]  req_stage = '0;
  logic        req_ready;
  logic        rsp_fire = 1'b0;
  logic [1:0]  rsp_stage = '0;
  logic [1:0]  stage = '0;
  tex_dcrs_t   tex_dcrs;
  logic [NS-1:0] commit_pending;
  logic        err_underflow;

  tex_dcr_staged_bank #(.NUM_STAGES(NS), .CNT_BITS(6), .DCR_ADDR_BITS(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .dcr_write_valid(dcr_write_valid), .dcr_write_addr(dcr_write_addr),
    .dcr_write_data(dcr_write_data), .dcr_read_valid(dcr_read_valid),
    .dcr_read_addr(dcr_read_addr), .dcr_rsp_valid(dcr_rsp_valid),
    .dcr_rsp_data(dcr_rsp_data), .req_valid(req_valid), .req_stage(req_stage),
    .req_ready(req_ready), .rsp_fire(rsp_fire), .rsp_stage(rsp_stage),
    .stage(stage), .tex_dcrs(tex_dcrs), .commit_pending(commit_pending),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // Reference model: each stage is a register image indexed by DCR offset.
  logic [31:0] m_sh  [NS][NOFF];
  logic [31:0] m_act [NS][NOFF];
  int          m_cnt [NS];
  bit          m_pend[NS];
  int          m_cur;
  bit          m_err;
  bit          m_rv;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fmask(input int off);
    case (off)
      1: return 32'hffff_ffff;
      2: return 32'h0000_0007;
      3: return 32'h0000_0003;
      4: return 32'h0003_0003;
      5: return 32'h000f_000f;
      default: return (off >= 7 && off < NOFF) ? 32'h000f_ffff : 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < NOFF; k++) begin
        m_sh[s][k] = '0;
        m_act[s][k] = '0;
      end
      m_cnt[s] = 0;
      m_pend[s] = 0;
    end
    m_cur = 0;
    m_err = 0;
    m_rv = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int off;
    off = int'(a) - BASE;
    if (off == 0) return 32'(m_cur);
    if (off == 6) return 32'(m_pend[m_cur]);
    if (fmask(off) != 0) return m_sh[m_cur][off];
    return 32'h0;
  endfunction

  function automatic tex_dcrs_t exp_tex(input int s);
    tex_dcrs_t t;
    t = '0;
    t.addr      = m_act[s][1];
    t.format    = m_act[s][2][2:0];
    t.filter    = m_act[s][3][1:0];
    t.wrap[0]   = m_act[s][4][1:0];
    t.wrap[1]   = m_act[s][4][17:16];
    t.logdim[0] = m_act[s][5][3:0];
    t.logdim[1] = m_act[s][5][19:16];
    for (int j = 0; j < NUM_MIPS; j++) t.mipoff[j] = m_act[s][7+j][19:0];
    return t;
  endfunction

  task automatic model_step();
    int rs, ps, cs, off;
    bit acc;
    bit pend_old[NS];
    rs = int'(req_stage);
    ps = int'(rsp_stage);
    cs = m_cur;
    acc = req_valid && !m_pend[rs] && (m_cnt[rs] != CNT_MAX);
    for (int s = 0; s < NS; s++) begin
      pend_old[s] = m_pend[s];
      if (m_pend[s] && m_cnt[s] == 0) begin
        for (int k = 0; k < NOFF; k++) m_act[s][k] = m_sh[s][k];
        m_pend[s] = 0;
      end
    end
    if (!(acc && rsp_fire && rs == ps)) begin
      if (acc) m_cnt[rs]++;
      if (rsp_fire) begin
        if (m_cnt[ps] == 0) m_err = 1;
        else m_cnt[ps]--;
      end
    end
    if (dcr_write_valid) begin
      off = int'(dcr_write_addr) - BASE;
      if (off == 0) begin
        m_cur = int'(dcr_write_data[1:0]);
        if (m_cur > NS - 1) m_cur = NS - 1;
      end else if (off == 6) begin
        if (!pend_old[cs]) m_pend[cs] = 1;
      end else if (fmask(off) != 0) begin
        m_sh[cs][off] = dcr_write_data & fmask(off);
      end
    end
    m_rv = dcr_read_valid;
  endtask

  task automatic check_all();
    logic [NS-1:0] pv;
    int rs;
    for (int s = 0; s < NS; s++) pv[s] = m_pend[s];
    rs = int'(req_stage);
    chk("commit_pending", commit_pending, pv);
    chk("err_underflow", err_underflow, m_err);
    chk("req_ready", req_ready, !m_pend[rs] && (m_cnt[rs] != CNT_MAX));
    chk("tex_dcrs", tex_dcrs, exp_tex(int'(stage)));
    chk("rsp_valid", dcr_rsp_valid, m_rv);
  endtask

  task automatic cyc();
    if (dcr_read_valid) exp_q.push_back(model_read(dcr_read_addr));
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    dcr_write_valid = 0;
    dcr_read_valid = 0;
    req_valid = 0;
    rsp_fire = 0;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    idle();
    dcr_write_valid = 1;
    dcr_write_addr = 12'(BASE + off);
    dcr_write_data = d;
    cyc();
    idle();
  endtask

  task automatic rd(input int a);
    idle();
    dcr_read_valid = 1;
    dcr_read_addr = 12'(a);
    cyc();
    idle();
  endtask

  task automatic req(input int s);
    idle();
    req_valid = 1;
    req_stage = 2'(s);
    cyc();
    idle();
  endtask

  task automatic rsp(input int s);
    idle();
    rsp_fire = 1;
    rsp_stage = 2'(s);
    cyc();
    idle();
  endtask

  always @(negedge clk) begin
    if (reset_n && dcr_rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL readback_unexpected: got %0h expected no response", dcr_rsp_data);
      end else begin
        chk("readback", dcr_rsp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    cyc();
    chk("reset_rsp_data", dcr_rsp_data, 0);

    // Commit with nothing in flight: pending for exactly one cycle.
    wr(0, 1);
    wr(2, 3);
    wr(6, 32'hdead_beef);
    chk("commit_armed", commit_pending, 4'b0010);
    stage = 1;
    cyc();
    chk("commit_done", commit_pending, 4'b0000);
    chk("active_format_s1", tex_dcrs.format, 3);
    stage = 0;
    cyc();
    chk("active_format_s0", tex_dcrs.format, 0);

    // Commit waits for three in-flight requests on stage 2.
    for (int i = 0; i < 3; i++) req(2);
    wr(0, 2);
    wr(3, 1);
    wr(6, 0);
    req_stage = 2;
    stage = 2;
    cyc();
    chk("holdoff_s2", req_ready, 0);
    rsp(2);
    rsp(2);
    chk("filter_before_drain", tex_dcrs.filter, 0);
    rsp(2);
    req_stage = 2;
    cyc();
    chk("filter_after_drain", tex_dcrs.filter, 1);
    chk("ready_after_drain", req_ready, 1);

    // Simultaneous accept and retire on stage 0, then underflow on stage 3.
    for (int i = 0; i < 4; i++) req(0);
    idle();
    req_valid = 1; req_stage = 0; rsp_fire = 1; rsp_stage = 0;
    cyc();
    idle();
    for (int i = 0; i < 4; i++) rsp(0);
    chk("no_underflow_yet", err_underflow, 0);
    rsp(3);
    chk("underflow_set", err_underflow, 1);
    repeat (3) cyc();
    chk("underflow_sticky", err_underflow, 1);

    // Counter saturation holds off stage 0.
    for (int i = 0; i < 63; i++) req(0);
    req_stage = 0;
    req_valid = 1;
    cyc();
    chk("full_holdoff", req_ready, 0);
    rsp(0);
    req_stage = 0;
    cyc();
    chk("ready_after_one_rsp", req_ready, 1);

    // Read-back of fields, COMMIT flag and unmapped addresses.
    wr(0, 1);
    wr(4, 32'h0002_0001);
    rd(BASE + 4);
    chk("rd_wrap", dcr_rsp_data, 32'h0002_0001);
    wr(0, 0);
    wr(6, 0);
    rd(BASE + 6);
    chk("rd_commit_pending", dcr_rsp_data, 1);
    rd(BASE + 40);
    chk("rd_unmapped_hi", dcr_rsp_data, 0);
    rd(BASE - 3);
    chk("rd_unmapped_lo", dcr_rsp_data, 0);
    cyc();

    // Reset while stage 0 is still draining.
    #1 reset_n = 0;
    #1;
    chk("rst_pending", commit_pending, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_rsp_valid", dcr_rsp_valid, 0);
    chk("rst_rsp_data", dcr_rsp_data, 0);
    chk("rst_tex", tex_dcrs, '0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1;
    rsp(0);
    chk("forgotten_inflight", err_underflow, 1);
    wr(0, 7);
    rd(BASE + 0);
    chk("stage_clamp", dcr_rsp_data, 3);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      idle();
      dcr_write_valid = ($urandom_range(0, 3) == 0);
      dcr_write_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(0, 4095))
                                                     : 12'(BASE + $urandom_range(0, 21));
      dcr_write_data  = $urandom;
      dcr_read_valid  = ($urandom_range(0, 2) == 0);
      dcr_read_addr   = 12'(BASE + $urandom_range(0, 22) - 1);
      req_valid       = $urandom_range(0, 1) == 1;
      req_stage       = 2'($urandom_range(0, 3));
      rsp_fire        = ($urandom_range(0, 4) < 2);
      rsp_stage       = 2'($urandom_range(0, 3));
      stage           = 2'($urandom_range(0, 3));
      cyc();
    end
    idle();
    repeat (3) cyc();
    chk("readback_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
